// File: rtl/fetch_unit.sv
// Purpose : P7 MIPS fetch stage; owns the PC, drives IM address, holds the F/D pipeline registers.
// Latency : IM address is combinational from F_PC; the fetched word lands in the D regs 1 cycle later.
// Backpr. : stall freezes F_PC and every D reg; req_exc overrides stall, eret and branches wait it out.
//
// Ports:
//   clk, reset (sync, active-low)     clock and reset
//   stall, br_taken/br_target         hazard freeze and decode-side PC redirect
//   D_branch                          instruction in D is a branch/jump -> F word is a delay slot
//   req_exc, eret/epc                 CP0 exception entry and exception return
//   i_inst_addr / i_inst_rdata        instruction memory address out / combinational read data in
//   F_PC                              current fetch PC
//   D_ins, D_PC, D_exc_code, D_bd     F/D register contents consumed by decode
//
// Build option: define FETCH_ADEL_CHECK_EN to flag misaligned or out-of-IM fetches as AdEL
// (exception code 4, instruction word zeroed). Without it, every fetch is treated as legal.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        D_branch,
  input  logic        req_exc,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] D_ins,
  output logic [31:0] D_PC,
  output logic [4:0]  D_exc_code,
  output logic        D_bd
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic adel;

`ifdef FETCH_ADEL_CHECK_EN
  // Unsigned 32-bit bounds; a wrapped PC (e.g. 0 after FFFF_FFFC) falls below IM_LO.
  assign adel = (F_PC[1:0] != 2'b00) || (F_PC < IM_LO) || (F_PC > IM_HI);
`else
  // Bounds are only meaningful when the address check is built in.
  logic unused_im_bounds;
  assign unused_im_bounds = ^{IM_LO, IM_HI};
  assign adel             = 1'b0;
`endif

  assign i_inst_addr = F_PC;

  always_ff @(posedge clk) begin
    if (!reset) begin
      F_PC       <= RESET_PC;
      D_ins      <= 32'd0;
      D_PC       <= RESET_PC;
      D_exc_code <= EXC_NONE;
      D_bd       <= 1'b0;
    end else if (req_exc) begin
      // Exception entry flushes D even when the pipe is stalled.
      F_PC       <= HANDLER_PC;
      D_ins      <= 32'd0;
      D_PC       <= HANDLER_PC;
      D_exc_code <= EXC_NONE;
      D_bd       <= 1'b0;
    end else if (eret && !stall) begin
      // eret has no delay slot: the word currently fetched is dropped.
      F_PC       <= epc;
      D_ins      <= 32'd0;
      D_PC       <= epc;
      D_exc_code <= EXC_NONE;
      D_bd       <= 1'b0;
    end else if (!stall) begin
      // An AdEL fetch still advances; CP0 raises req_exc once it reaches a later stage.
      F_PC       <= br_taken ? br_target : F_PC + 32'd4;
      D_PC       <= F_PC;
      D_bd       <= D_branch;
      D_ins      <= adel ? 32'd0 : i_inst_rdata;
      D_exc_code <= adel ? EXC_ADEL : EXC_NONE;
    end
    // stall with no req_exc: every register holds, br_taken/eret are re-presented later.
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose : randomized self-checking bench for fetch_unit against a behavioural PC/F-D model.
// Latency : model state is compared 1 time unit after each rising clock edge.
// Backpr. : stall is exercised directly and randomly; the bench never waits on a DUT handshake.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, D_branch, req_exc, eret;
  logic [31:0] br_target, epc;
  logic [31:0] i_inst_addr, i_inst_rdata, F_PC, D_ins, D_PC;
  logic [4:0]  D_exc_code;
  logic        D_bd;

  // Instruction memory: constant word or an address-derived pattern.
  logic im_const;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_fpc, m_dins, m_dpc;
  logic [4:0]  m_exc;
  logic        m_bd;

  fetch_unit #(
    .RESET_PC(RESET_PC), .HANDLER_PC(HANDLER_PC), .IM_LO(IM_LO), .IM_HI(IM_HI)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .D_branch(D_branch), .req_exc(req_exc), .eret(eret), .epc(epc),
    .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata), .F_PC(F_PC),
    .D_ins(D_ins), .D_PC(D_PC), .D_exc_code(D_exc_code), .D_bd(D_bd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] im_word(input logic cst, input logic [31:0] a);
    if (cst) return 32'h1111_1111;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  always_comb i_inst_rdata = im_word(im_const, i_inst_addr);

  function automatic bit is_adel(input logic [31:0] pc);
`ifdef FETCH_ADEL_CHECK_EN
    return (pc % 4 != 0) || (pc < IM_LO) || (pc > IM_HI);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("F_PC",        F_PC,        m_fpc);
    check_val("i_inst_addr", i_inst_addr, m_fpc);
    check_val("D_ins",       D_ins,       m_dins);
    check_val("D_PC",        D_PC,        m_dpc);
    check_val("D_exc_code",  {27'd0, D_exc_code}, {27'd0, m_exc});
    check_val("D_bd",        {31'd0, D_bd},       {31'd0, m_bd});
  endtask

  // One clock: drive at negedge, advance the model at the edge, compare just after.
  task automatic cycle(input logic rst, input logic stl, input logic brt, input logic [31:0] tgt,
                       input logic dbr, input logic exc, input logic er, input logic [31:0] ep);
    @(negedge clk);
    reset = rst; stall = stl; br_taken = brt; br_target = tgt;
    D_branch = dbr; req_exc = exc; eret = er; epc = ep;
    @(posedge clk);
    if (!rst) begin
      m_fpc = RESET_PC; m_dins = 0; m_dpc = RESET_PC; m_exc = 0; m_bd = 0;
    end else if (exc) begin
      m_fpc = HANDLER_PC; m_dins = 0; m_dpc = HANDLER_PC; m_exc = 0; m_bd = 0;
    end else if (er && !stl) begin
      m_fpc = ep; m_dins = 0; m_dpc = ep; m_exc = 0; m_bd = 0;
    end else if (!stl) begin
      m_dpc  = m_fpc;
      m_bd   = dbr;
      m_dins = is_adel(m_fpc) ? 32'd0 : im_word(im_const, m_fpc);
      m_exc  = is_adel(m_fpc) ? 5'd4 : 5'd0;
      m_fpc  = brt ? tgt : m_fpc + 32'd4;
    end
    #1;
    check_all();
  endtask

  task automatic free_cycle(input logic dbr);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, dbr, 1'b0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 5))
      0, 1:    return IM_LO + 32'($urandom_range(0, 4095)) * 32'd4;
      2:       return IM_LO + 32'($urandom_range(0, 4095)) * 32'd4 + 32'($urandom_range(1, 3));
      3:       return $urandom;
      4:       return ($urandom_range(0, 1) != 0) ? IM_HI : IM_HI + 32'd4;
      default: return ($urandom_range(0, 1) != 0) ? IM_LO : IM_LO - 32'd4;
    endcase
  endfunction

  initial begin
    reset = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; D_branch = 1'b0;
    req_exc = 1'b0; eret = 1'b0; epc = 32'h0; im_const = 1'b1;
    m_fpc = RESET_PC; m_dins = 0; m_dpc = RESET_PC; m_exc = 0; m_bd = 0;

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("rst_F_PC", F_PC, 32'h0000_3000);
    check_val("rst_D_ins", D_ins, 32'h0);

    // Free-running sequence with constant IM data
    free_cycle(1'b0);
    check_val("seq_F_PC_3004", F_PC, 32'h0000_3004);
    check_val("seq_D_PC_3000", D_PC, 32'h0000_3000);
    check_val("seq_D_ins", D_ins, 32'h1111_1111);
    free_cycle(1'b0);
    check_val("seq_F_PC_3008", F_PC, 32'h0000_3008);

    // Taken branch from 3008 with D_branch set: 3008 is the delay slot
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_3100, 1'b1, 1'b0, 1'b0, 32'h0);
    check_val("br_F_PC", F_PC, 32'h0000_3100);
    check_val("br_D_PC", D_PC, 32'h0000_3008);
    check_val("br_D_bd", {31'd0, D_bd}, 32'd1);
    im_const = 1'b0;

    // Stall for two cycles with a pending branch that must be ignored
    free_cycle(1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_5000, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_5000, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("stall_F_PC", F_PC, 32'h0000_3104);
    free_cycle(1'b0);

    // Exception request overrides stall and eret
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_5000, 1'b0, 1'b1, 1'b1, 32'h0000_3024);
    check_val("exc_F_PC", F_PC, HANDLER_PC);
    check_val("exc_D_PC", D_PC, HANDLER_PC);
    free_cycle(1'b0);

    // eret held off by stall, then taken
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_3024);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_3024);
    check_val("eret_F_PC", F_PC, 32'h0000_3024);
    check_val("eret_D_ins", D_ins, 32'h0);

    // Misaligned branch target: the next D load is AdEL only with the check built in
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_3002, 1'b0, 1'b0, 1'b0, 32'h0);
    free_cycle(1'b0);
`ifdef FETCH_ADEL_CHECK_EN
    check_val("adel_code", {27'd0, D_exc_code}, 32'd4);
    check_val("adel_ins", D_ins, 32'h0);
`else
    check_val("noadel_code", {27'd0, D_exc_code}, 32'd0);
    check_val("noadel_ins", D_ins, im_word(1'b0, 32'h0000_3002));
`endif

    // Wrap-around at the top of the address space
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
    free_cycle(1'b0);
    check_val("wrap_F_PC", F_PC, 32'h0);
    free_cycle(1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic rst, stl, brt, dbr, exc, er;
      rst = ($urandom_range(0, 99) != 0);
      stl = ($urandom_range(0, 3) == 0);
      brt = ($urandom_range(0, 3) == 0);
      dbr = ($urandom_range(0, 3) == 0);
      exc = ($urandom_range(0, 39) == 0);
      er  = ($urandom_range(0, 19) == 0);
      cycle(rst, stl, brt, rand_target(), dbr, exc, er, rand_target());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch (F) stage plus F/D pipeline register of the P7 MIPS pipeline. It owns the program counter, drives the instruction-memory address, and captures the fetched word into the D-stage registers that the decode stage consumes. It applies the redirects decode and CP0 feed back into it, in priority order: exception entry, `eret`, stall, branch/jump, sequential. It also tags each fetched word with its fetch-side exception code and delay-slot flag.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: PC value after reset.
- `HANDLER_PC`, 32'h0000_4180: exception/interrupt entry address.
- `IM_LO`, 32'h0000_3000: lowest legal fetch address.
- `IM_HI`, 32'h0000_6FFC: highest legal fetch address, inclusive.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low. `reset`=0 at a rising edge resets the block.
- `stall` in 1: hazard stall from the hazard unit.
- `br_taken` in 1: decode stage's PC-write enable (branch taken or jump).
- `br_target` in 32: decode stage's next-PC.
- `D_branch` in 1: instruction currently in D is a branch or jump, so the F word is in a delay slot.
- `req_exc` in 1: CP0 exception or interrupt request.
- `eret` in 1: `eret` is in D.
- `epc` in 32: CP0 EPC.
- `i_inst_addr` out 32: instruction-memory address, equal to `F_PC`.
- `i_inst_rdata` in 32: combinational instruction-memory read data.
- `F_PC` out 32: current PC.
- `D_ins` out 32: instruction register to D.
- `D_PC` out 32: PC register to D.
- `D_exc_code` out 5: fetch exception code to D.
- `D_bd` out 1: delay-slot flag to D.

## Operation
- On reset:
  - `F_PC`=`RESET_PC`.
  - `D_ins`=0.
  - `D_PC`=`RESET_PC`.
  - `D_exc_code`=0.
  - `D_bd`=0.
- Each edge with `reset`=1, the first matching rule applies:
  1. `req_exc`=1: `F_PC`<=`HANDLER_PC`. D regs are flushed: `D_ins`=0, `D_PC`=`HANDLER_PC`, `D_exc_code`=0, `D_bd`=0. This rule overrides `stall`.
  2. `eret`=1 and `stall`=0: `F_PC`<=`epc`. D regs are flushed as in rule 1, except `D_PC`=`epc`. The delay-slot word after `eret` is discarded.
  3. `stall`=1: `F_PC` and all D regs hold. A pending `br_taken` is ignored this cycle; decode re-asserts it once the stall releases.
  4. `br_taken`=1: `F_PC`<=`br_target`. The D regs load the current fetch, which is the delay slot.
  5. Otherwise: `F_PC`<=`F_PC`+4, modulo 2^32. The D regs load the current fetch.
- Loading the current fetch:
  - `D_PC`<=`F_PC`.
  - `D_bd`<=`D_branch`.
  - `D_ins`<=`i_inst_rdata`, or 0 when `adel`=1.
  - `D_exc_code`<=4 (AdEL) when `adel`=1, else 0.
- `adel` is 1 when any of the following holds:
  - `F_PC[1:0]`!=0;
  - `F_PC`<`IM_LO`;
  - `F_PC`>`IM_HI`.
  The comparisons are unsigned, 32-bit.
- An AdEL fetch never stops the PC from advancing. The exception is taken later through `req_exc`.

## Timing
- `i_inst_addr` is combinational from `F_PC`. The instruction reaches the D regs 1 cycle after `F_PC` shows its address.
- Redirect latency is 1 cycle. The PC selected at edge N is fetched in cycle N+1.
- `stall` only freezes state; `F_PC` and the D regs stay constant for as many cycles as `stall` is held.
- Simultaneous events:
  - `req_exc` with `eret`, `stall` or `br_taken`: `req_exc` wins.
  - `eret` with `stall`: the stall wins and `eret` is re-evaluated next cycle.
- Reset asserted mid-stall or mid-redirect takes effect at that edge, and all pending redirects are dropped.
- Wrap-around: `F_PC`=32'hFFFF_FFFC steps to 0. Both addresses raise `adel`.

## Configuration
- `FETCH_ADEL_CHECK_EN` defined: `adel` is computed as above.
- Not defined: `adel` is tied to 0, `D_exc_code` is always 0, and `D_ins` always takes `i_inst_rdata`. Used for the exception-free P5/P6 style benches.

## Test plan
- Reset then 3 free cycles, IM returning 32'h1111_1111: `F_PC` = 3000, 3004, 3008, 300C; `D_PC` lags by 1 cycle; `D_ins`=32'h1111_1111.
- `br_taken`=1 with `br_target`=32'h0000_3100 at `F_PC`=3008, `D_branch`=1: next `F_PC`=3100; `D_PC`=3008 with `D_bd`=1.
- `stall`=1 for 2 cycles at `F_PC`=3010: `F_PC` and D regs unchanged for both cycles; 300C/3010 sequence resumes after release.
- `req_exc`=1 while `stall`=1: `F_PC`=4180, `D_ins`=0, `D_PC`=4180, `D_exc_code`=0.
- `eret`=1 with `epc`=32'h0000_3024: `F_PC`=3024, `D_ins`=0; with `stall` also set, no change until `stall` drops.
- Macro defined, `br_target`=32'h0000_3002: the next D load has `D_exc_code`=4 and `D_ins`=0. Repeat with the macro undefined: `D_exc_code`=0 and `D_ins`=IM data.
